uart_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte producers.
- Accepts one byte per requester through a valid/ready handshake and drives the transmitter's parallel data and one-cycle start pulse.
- The transmitter has no busy output, so the block times each frame internally. It then enforces a guard gap before granting the next requester.
- Sits between producer logic and the transmitter instance, on the same clk/prst domain.

---
 rtl/uart_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. Each granted byte is presented on tx_data with a one-cycle
// tx_start pulse. The frame is then timed internally, because the
// transmitter has no busy flag. A guard gap follows before the next grant.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            prst,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_start,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [1:0]                      dbg_state
);

  localparam int IDX_W        = $clog2(NUM_REQ);
  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  // START covers one cycle of the frame. WAIT counts the remaining cycles down to 0.
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [CNT_W-1:0] GUARD_LOAD =
    CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
  localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GUARD = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;

  logic [NUM_REQ-1:0]     rot;
  logic [IDX_W:0]         sum;
  logic [IDX_W-1:0]       sel;
  logic                   sel_found;
  logic [DATA_WIDTH-1:0]  sel_byte;
  logic                   accept;

  // Rotate the valids so the pointer sits at bit 0. The lowest set bit then
  // gives the first requester found scanning upward from the pointer.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    sum       = '0;
    sel_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum       = {1'b0, ptr_q} + (IDX_W+1)'(k);
        sel_found = 1'b1;
      end
    end
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    sel = sum[IDX_W-1:0];
  end

  // Byte mux for the selected requester.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IDX_W'(k)) begin
        sel_byte = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake: req_ready[i] is driven combinationally, and only in IDLE with
  // enable high. It is one-hot on the selected requester. A transfer happens on
  // the rising edge where req_valid[i] and req_ready[i] are both high. Valid
  // outside IDLE is ignored, and data is sampled only on that edge. The
  // reset-input term keeps ready low while reset is held.
  assign accept    = prst & enable & sel_found & (state_q == S_IDLE);
  assign req_ready = accept ? (NUM_REQ'(1) << sel) : '0;

  // Next-state and datapath decisions for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_data_d  = sel_byte;
          grant_d    = sel;
          ptr_d      = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          tx_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        cnt_d   = FRAME_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (GUARD_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = GUARD_LOAD;
            state_d = S_GUARD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, pointer and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge prst) begin
    if (!prst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler. A frame-level model (busy countdown, round-robin
// pointer) predicts every output on each negedge. Directed scenarios pin
// literal values. A randomized phase follows.
module tb_uart_tx_scheduler;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int CPB      = 16;
  localparam int FB       = 10;
  localparam int GC       = 2;
  localparam int FRAME    = FB * CPB;
  localparam int BUSY_LEN = FRAME + GC;
  localparam int IW       = $clog2(N);

  logic           clk       = 1'b0;
  logic           prst      = 1'b1;
  logic           enable    = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic [1:0]     dbg_state;

  uart_tx_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(W), .CLKS_PER_BIT(CPB),
    .FRAME_BITS(FB), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .prst(prst), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // m_left counts the non-idle cycles still ahead. A frame occupies BUSY_LEN
  // cycles after its accept edge, and tx_start falls on the first of them.
  int           m_left  = 0;
  int           m_ptr   = 0;
  int           m_grant = 0;
  logic [W-1:0] m_data  = '0;
  logic [W-1:0] exp_q[$];
  logic [N-1:0] acc_seen = '0;

  always @(negedge clk) begin : compare_proc
    int           sel;
    bit           found;
    logic [N-1:0] er;
    logic [W-1:0] want;
    if (!prst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_tx_start",  32'(tx_start),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_tx_data",   32'(tx_data),   32'd0);
      check("rst_grant_id",  32'(grant_id),  32'd0);
      m_left = 0; m_ptr = 0; m_grant = 0; m_data = '0;
      exp_q.delete();
      acc_seen = '0;
    end else begin
      found = 1'b0;
      sel   = 0;
      if (m_left == 0 && enable) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            sel   = (m_ptr + k) % N;
            found = 1'b1;
          end
        end
      end
      er = found ? (N'(1) << sel) : '0;
      check("req_ready", 32'(req_ready), 32'(er));
      check("tx_start",  32'(tx_start),  32'(m_left == BUSY_LEN));
      check("busy",      32'(busy),      32'(m_left > 0));
      check("tx_data",   32'(tx_data),   32'(m_data));
      check("grant_id",  32'(grant_id),  32'(m_grant));
      check("dbg_idle",  32'(dbg_state == 2'd0), 32'(m_left == 0));
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_start: got start with data 0x%0h expected no start (cycle %0d)", tx_data, cyc);
        end else begin
          want = exp_q.pop_front();
          check("sb_tx_data", 32'(tx_data), 32'(want));
        end
      end
      acc_seen = req_ready;
      if (found) begin
        m_data  = req_data[sel*W +: W];
        m_grant = sel;
        m_ptr   = (sel + 1) % N;
        m_left  = BUSY_LEN;
        exp_q.push_back(m_data);
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [W-1:0] b);
    req_data[i*W +: W] = b;
  endtask

  task automatic wait_accept(output int id);
    id = -1;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (acc_seen != '0) begin
        for (int k = 0; k < N; k++) if (acc_seen[k]) id = k;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no accept expected one within 1000 cycles");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 1000; n++) begin
      tick();
      #2;
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy expected idle within 1000 cycles");
  endtask

  // Called in the start cycle; counts busy cycles including this one.
  task automatic count_busy(output int n);
    n = 1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      #2;
      if (busy) n++;
      else return;
    end
    checks++;
    errors++;
    $display("FAIL busy_timeout: got busy expected idle within 1000 cycles");
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int           id;
    int           n;
    int           sc[$];
    logic [W-1:0] sd[$];
    logic [W-1:0] rr_exp[5];

    #2 prst = 1'b0;
    repeat (3) @(posedge clk);
    #1 prst = 1'b1;
    #2;
    check("post_rst_busy",  32'(busy),      32'd0);
    check("post_rst_ready", 32'(req_ready), 32'd0);
    check("post_rst_grant", 32'(grant_id),  32'd0);

    // Single byte from requester 2.
    tick();
    enable = 1'b1;
    set_byte(2, 8'hA5);
    req_valid = 4'b0100;
    #2 check("t1_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #2;
    check("t1_start",   32'(tx_start), 32'd1);
    check("t1_data",    32'(tx_data),  32'hA5);
    check("t1_grant",   32'(grant_id), 32'd2);
    count_busy(n);
    check("t1_busy_len", 32'(n), 32'd162);

    // Reset partway through WAIT, then requester 1 right after release.
    tick();
    set_byte(0, 8'h5A);
    req_valid = 4'b0001;
    wait_accept(id);
    check("t2_first_id", 32'(id), 32'd0);
    req_valid = '0;
    repeat (80) tick();
    #2 prst = 1'b0;
    #1;
    check("t2_rst_busy",  32'(busy),      32'd0);
    check("t2_rst_data",  32'(tx_data),   32'd0);
    check("t2_rst_start", 32'(tx_start),  32'd0);
    check("t2_rst_grant", 32'(grant_id),  32'd0);
    set_byte(1, 8'hC3);
    req_valid = 4'b0010;
    #1 check("t2_rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    prst = 1'b1;
    #2 check("t2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #2;
    check("t2_start", 32'(tx_start), 32'd1);
    check("t2_data",  32'(tx_data),  32'hC3);
    check("t2_grant", 32'(grant_id), 32'd1);
    count_busy(n);
    check("t2_busy_len", 32'(n), 32'd162);

    // Round robin under full demand, starting from a fresh pointer.
    tick();
    prst = 1'b0;
    tick();
    prst = 1'b1;
    for (int i = 0; i < N; i++) set_byte(i, 8'(8'h10 + i));
    req_valid = 4'hF;
    for (int k = 0; k < 1000 && sc.size() < 5; k++) begin
      tick();
      #2;
      if (tx_start) begin
        sc.push_back(cyc);
        sd.push_back(tx_data);
      end
    end
    req_valid = '0;
    check("rr_count", 32'(sc.size()), 32'd5);
    rr_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    for (int i = 0; i < sd.size() && i < 5; i++) check("rr_data", 32'(sd[i]), 32'(rr_exp[i]));
    for (int i = 1; i < sc.size(); i++) check("rr_spacing", 32'(sc[i] - sc[i-1]), 32'd163);
    wait_idle();

    // Pointer wrap: grant 3, then 0 and 2 pending.
    req_valid = 4'b1000;
    wait_accept(id);
    check("pw_id3", 32'(id), 32'd3);
    req_valid = 4'b0101;
    wait_accept(id);
    check("pw_id0", 32'(id), 32'd0);
    req_valid = 4'b0100;
    wait_accept(id);
    check("pw_id2", 32'(id), 32'd2);
    req_valid = '0;
    wait_idle();

    // Enable dropped mid-frame with a byte still pending.
    set_byte(1, 8'h77);
    req_valid = 4'b0010;
    wait_accept(id);
    check("en_id", 32'(id), 32'd1);
    set_byte(1, 8'h78);
    repeat (50) tick();
    enable = 1'b0;
    wait_idle();
    for (int k = 0; k < 20; k++) begin
      check("en_gated_ready", 32'(req_ready), 32'd0);
      tick();
      #2;
    end
    enable = 1'b1;
    #1 check("en_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1;
    check("en_start", 32'(tx_start), 32'd1);
    check("en_data",  32'(tx_data),  32'h78);
    wait_idle();

    // Randomized traffic: producers hold valid until accepted. Some drop valid,
    // change data or toggle enable mid-frame, plus one reset.
    for (int c = 0; c < 8000; c++) begin
      tick();
      if (c == 4000) prst = 1'b0;
      if (c == 4002) prst = 1'b1;
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && acc_seen[i]) begin
          if ($urandom_range(0, 1) == 1) set_byte(i, 8'($urandom_range(0, 255)));
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) begin
            req_valid[i] = 1'b1;
            set_byte(i, 8'($urandom_range(0, 255)));
          end
        end else begin
          if ($urandom_range(0, 49) == 0) set_byte(i, 8'($urandom_range(0, 255)));
          if ($urandom_range(0, 99) == 0) req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    wait_idle();
    repeat (2) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
